// File: rtl/apu_clk_pkg.sv
// Shared constants and AUX bus field layouts for the APU clock/phase front end.
package apu_clk_pkg;

  localparam int DIV_PERIOD = 12;
  localparam int PHI0_HIGH  = 6;
  localparam int DIV_W      = 4;

  localparam int AUX_A_W = 8;
  localparam int AUX_B_W = 15;
  localparam int MIX_W   = 32;

  // Weights are linear DAC approximations scaled by 2^16.
  localparam logic [MIX_W-1:0] W_SQ    = 32'd493;
  localparam logic [MIX_W-1:0] W_TRI   = 32'd558;
  localparam logic [MIX_W-1:0] W_NOISE = 32'd324;
  localparam logic [MIX_W-1:0] W_DMC   = 32'd220;

  typedef struct packed {
    logic [3:0] sq2;
    logic [3:0] sq1;
  } aux_a_t;

  typedef struct packed {
    logic [6:0] dmc;
    logic [3:0] noise;
    logic [3:0] tri_lvl;
  } aux_b_t;

endpackage

// File: rtl/aux_mixer.sv
// Weighted sums of the channel levels, registered once; scale 2^-16.
module aux_mixer
  import apu_clk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  aux_a_t           aux_a,
  input  aux_b_t           aux_b,
  output logic [MIX_W-1:0] a_out,
  output logic [MIX_W-1:0] b_out
);

  logic [MIX_W-1:0] a_sum_p0;
  logic [MIX_W-1:0] b_sum_p0;
  logic [MIX_W-1:0] a_p1;
  logic [MIX_W-1:0] b_p1;

  function automatic logic [MIX_W-1:0] mix_sq(input aux_a_t a);
    return W_SQ * (MIX_W'(a.sq1) + MIX_W'(a.sq2));
  endfunction

  function automatic logic [MIX_W-1:0] mix_tnd(input aux_b_t b);
    return W_TRI * MIX_W'(b.tri_lvl) + W_NOISE * MIX_W'(b.noise)
         + W_DMC * MIX_W'(b.dmc);
  endfunction

  // Stage p0: combinational weighted sums (max 41170, no overflow)
  always_comb begin
    a_sum_p0 = mix_sq(aux_a);
    b_sum_p0 = mix_tnd(aux_b);
  end

  // Stage p1: output registers; reset clears the mix as well
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1 <= '0;
      b_p1 <= '0;
    end else begin
      a_p1 <= a_sum_p0;
      b_p1 <= b_sum_p0;
    end
  end

  assign a_out = a_p1;
  assign b_out = b_p1;

endmodule

// File: rtl/aclk_gen.sv
// Master-clock /12 CPU phase generator, /2 APU strobe generator and AUX mixer.
module aclk_gen
  import apu_clk_pkg::*;
(
  input  logic               CLK,
  input  logic               RES,
  output logic               PHI0,
  output logic               PHI1,
  output logic               PHI2,
  output logic               ACLK1,
  output logic               nACLK2,
  input  logic [AUX_A_W-1:0] AUX_A,
  input  logic [AUX_B_W-1:0] AUX_B,
  output logic [MIX_W-1:0]   AOut,
  output logic [MIX_W-1:0]   BOut
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_PERIOD - 1);
  localparam logic [DIV_W-1:0] PHI0_LIM = DIV_W'(PHI0_HIGH);

  logic [DIV_W-1:0] div_cnt;
  logic             aclk_t;

  // aclk_t flips on the 11->0 wrap, so it selects ACLK1 or ACLK2 per CPU cycle
  always_ff @(posedge CLK) begin
    if (RES) begin
      div_cnt <= '0;
      aclk_t  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      aclk_t  <= ~aclk_t;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    PHI0   = (div_cnt < PHI0_LIM);
    PHI1   = ~PHI0;
    PHI2   = PHI0;
    ACLK1  = PHI1 & ~aclk_t;
    nACLK2 = ~(PHI1 & aclk_t);
  end

  aux_mixer u_aux_mixer (
    .clk   (CLK),
    .rst   (RES),
    .aux_a (aux_a_t'(AUX_A)),
    .aux_b (aux_b_t'(AUX_B)),
    .a_out (AOut),
    .b_out (BOut)
  );

endmodule

// File: tb/tb_aclk_gen.sv
// Directed bench for aclk_gen: phases, ACLK alternation, mid-run reset, mixer.
module tb_aclk_gen;

  logic        CLK = 1'b0;
  logic        RES;
  logic        PHI0, PHI1, PHI2, ACLK1, nACLK2;
  logic [7:0]  AUX_A;
  logic [14:0] AUX_B;
  logic [31:0] AOut, BOut;

  int n_checks = 0;
  int n_fail   = 0;

  aclk_gen dut (
    .CLK    (CLK),
    .RES    (RES),
    .PHI0   (PHI0),
    .PHI1   (PHI1),
    .PHI2   (PHI2),
    .ACLK1  (ACLK1),
    .nACLK2 (nACLK2),
    .AUX_A  (AUX_A),
    .AUX_B  (AUX_B),
    .AOut   (AOut),
    .BOut   (BOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // k = number of edges since RES was released
  task automatic phase_run(input string tag);
    logic exp_phi0, exp_a1, exp_n2;
    for (int k = 1; k <= 48; k++) begin
      tick();
      exp_phi0 = ((k % 12) < 6);
      exp_a1   = (k >= 6 && k <= 11) || (k >= 30 && k <= 35);
      exp_n2   = !((k >= 18 && k <= 23) || (k >= 42 && k <= 47));
      check($sformatf("%s_phi0_k%0d", tag, k), 32'(PHI0), 32'(exp_phi0));
      check($sformatf("%s_phi1_k%0d", tag, k), 32'(PHI1), 32'(!exp_phi0));
      check($sformatf("%s_phi2_k%0d", tag, k), 32'(PHI2), 32'(exp_phi0));
      check($sformatf("%s_aclk1_k%0d", tag, k), 32'(ACLK1), 32'(exp_a1));
      check($sformatf("%s_naclk2_k%0d", tag, k), 32'(nACLK2), 32'(exp_n2));
      check($sformatf("%s_overlap_k%0d", tag, k), 32'(ACLK1 & ~nACLK2), 32'd0);
    end
  endtask

  initial begin
    RES   = 1'b1;
    AUX_A = 8'h00;
    AUX_B = 15'h0000;

    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_phi0", 32'(PHI0), 32'd1);
      check("rst_phi1", 32'(PHI1), 32'd0);
      check("rst_phi2", 32'(PHI2), 32'd1);
      check("rst_aclk1", 32'(ACLK1), 32'd0);
      check("rst_naclk2", 32'(nACLK2), 32'd1);
      check("rst_aout", AOut, 32'd0);
      check("rst_bout", BOut, 32'd0);
    end

    RES = 1'b0;
    phase_run("por");

    // Advance into the next nACLK2 low window (edges 66..71 after release)
    for (int k = 49; k <= 66; k++) tick();
    check("pre_midrst_naclk2", 32'(nACLK2), 32'd0);

    RES = 1'b1;
    tick();
    check("midrst_naclk2", 32'(nACLK2), 32'd1);
    check("midrst_aclk1", 32'(ACLK1), 32'd0);
    check("midrst_phi0", 32'(PHI0), 32'd1);
    RES = 1'b0;
    phase_run("restart");

    AUX_B = {7'd0, 4'hF, 4'h0};
    check("noise_latency", BOut, 32'd0);
    tick();
    check("noise_bout", BOut, 32'd4860);
    AUX_B = 15'h0000;
    tick();
    check("noise_zero", BOut, 32'd0);

    AUX_A = 8'h31;
    AUX_B = {7'd5, 4'd2, 4'd3};
    tick();
    check("mix_aout", AOut, 32'd1972);
    check("mix_bout", BOut, 32'd3422);

    AUX_A = 8'hFF;
    AUX_B = 15'h7FFF;
    check("fs_latency_a", AOut, 32'd1972);
    tick();
    check("fs_aout", AOut, 32'd14790);
    check("fs_bout", BOut, 32'd41170);

    RES = 1'b1;
    tick();
    check("fs_rst_aout", AOut, 32'd0);
    check("fs_rst_bout", BOut, 32'd0);
    tick();
    check("fs_rst_hold_aout", AOut, 32'd0);
    check("fs_rst_hold_bout", BOut, 32'd0);
    RES = 1'b0;
    tick();
    check("fs_release_aout", AOut, 32'd14790);
    check("fs_release_bout", BOut, 32'd41170);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
